receptor_uart: RTL and testbench
================================

RECEPTOR_UART -- requirements
Module: receptor_uart

Interface
REQ-001 The block SHALL have parameter DBIT, default 8, meaning number of data bits per frame (legal 5..8).
REQ-002 The block SHALL have parameter SB_TICK, default 16, meaning number of s_tick periods spent in the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2).
REQ-003 The block SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 The block SHALL have port rx, input, 1, asynchronous serial line, idle high, LSB first.
REQ-006 The block SHALL have port s_tick, input, 1, one-clk enable pulse at 16x the baud rate.
REQ-007 The block SHALL have port dout, output, 8, last received data word, right-aligned, unused upper bits 0.
REQ-008 The block SHALL have port rx_done, output, 1, one-clk pulse marking a completed frame.
REQ-009 The block SHALL have port frame_err, output, 1, stop-bit error flag for the frame marked by rx_done.

Function
REQ-010 The block SHALL pass rx through a 2-flop synchronizer (both flops reset to 1); all decisions SHALL use the synchronized value rx_s.
REQ-011 The block SHALL implement FSM states idle, start, data and stop, with a 4-bit or wider tick counter s, a 3-bit bit counter n and an 8-bit shift register b.
REQ-012 In idle, the block SHALL ignore s_tick; when rx_s is 0, it SHALL go to start with s = 0.
REQ-013 In start, on s_tick with s = 7 (start-bit midpoint): if rx_s = 0, it SHALL go to data with s = 0 and n = 0; if rx_s = 1, it SHALL treat the event as a glitch and return to idle without any output change.
REQ-014 In start, on s_tick with s < 7, the block SHALL set s = s + 1.
REQ-015 In data, on s_tick with s = 15, the block SHALL set s = 0, shift b = {rx_s, b[7:1]}, and go to stop if n = DBIT-1, else set n = n + 1.
REQ-016 In data, on s_tick with s < 15, the block SHALL set s = s + 1.
REQ-017 In stop, on s_tick with s = SB_TICK-1, the block SHALL return to idle and register dout = b >> (8-DBIT), frame_err = ~rx_s, and rx_done = 1.
REQ-018 In stop, on s_tick with s < SB_TICK-1, the block SHALL set s = s + 1.
REQ-019 Without s_tick, no counter or state SHALL change except the idle-to-start transition.
REQ-020 rx_done SHALL be high for exactly one clk, in the cycle after the final stop s_tick edge.
REQ-021 dout and frame_err SHALL become valid in the same cycle as rx_done and SHALL hold until the next rx_done.
REQ-022 A frame with a bad stop bit SHALL still deliver dout and rx_done, with frame_err = 1.
REQ-023 On a break (rx held low), the block SHALL report dout = 0 with frame_err = 1, then re-enter start immediately from idle while rx_s stays low.
REQ-024 Nominal latency from rx_s falling to rx_done SHALL be (8 + 16*DBIT + SB_TICK) s_tick periods plus 1 clk.
REQ-025 The block SHALL drop no frame when the next start bit follows immediately after the stop-bit sample.

Reset
REQ-026 While reset = 1, state SHALL be idle, s = 0, n = 0, b = 0, dout = 0, rx_done = 0, frame_err = 0, and the synchronizer flops SHALL be 1.
REQ-027 Reset asserted mid-frame SHALL abort the frame with no rx_done pulse; reset SHALL take priority over a coincident s_tick.
REQ-028 After reset is released, the block SHALL wait for a fresh falling edge of rx_s; a line already low at release SHALL be treated as a start bit.

Verification
REQ-029 Test 1: s_tick every 16 clk, frame 0x55 with a good stop bit -> dout = 0x55, frame_err = 0, exactly one rx_done.
REQ-030 Test 2: rx low for 4 s_tick periods, then high -> no rx_done, FSM back in idle, dout unchanged.
REQ-031 Test 3: frame 0xA3 with stop bit = 0 -> dout = 0xA3, frame_err = 1, one rx_done.
REQ-032 Test 4: back-to-back frames 0x00 then 0xFF with no idle gap -> two rx_done pulses, dout = 0x00 then 0xFF, frame_err = 0 for both.
REQ-033 Test 5: reset pulsed during data bit 4 of 0x3C, then a clean 0x81 frame -> no rx_done for 0x3C, then dout = 0x81.
REQ-034 Test 6: DBIT = 7, frame 0x5A (7 bits) -> dout = 0x5A, bit 7 = 0.

Source files
------------

// File: rtl/receptor_uart.sv
// UART receiver with 16x oversampling: samples each bit at its midpoint, LSB first,
// and reports the word with a one-clock done pulse and a stop-bit error flag.
module receptor_uart #(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  input  logic       s_tick,
  output logic [7:0] dout,
  output logic       rx_done,
  output logic       frame_err
);

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  // Tick counter must reach SB_TICK-1 = 31 for two stop bits.
  localparam int unsigned SW = 6;
  localparam logic [SW-1:0] MidStart = SW'(7);
  localparam logic [SW-1:0] BitLast  = SW'(15);
  localparam logic [SW-1:0] StopLast = SW'(SB_TICK - 1);
  localparam logic [2:0]    DataLast = 3'(DBIT - 1);
  localparam int unsigned   Shift    = 8 - DBIT;

  state_e        state_q, state_d;
  logic [SW-1:0] s_q, s_d;
  logic [2:0]    n_q, n_d;
  logic [7:0]    b_q, b_d;
  logic [7:0]    dout_q, dout_d;
  logic          done_q, done_d;
  logic          ferr_q, ferr_d;
  logic          rx_meta, rx_s;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      s_q     <= '0;
      n_q     <= '0;
      b_q     <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      n_q     <= n_d;
      b_q     <= b_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    n_d     = n_q;
    b_d     = b_q;
    dout_d  = dout_q;
    ferr_d  = ferr_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!rx_s) begin
          state_d = StStart;
          s_d     = '0;
        end
      end
      StStart: begin
        if (s_tick) begin
          if (s_q == MidStart) begin
            // A line that is high again at the midpoint was only a glitch.
            if (!rx_s) begin
              state_d = StData;
              s_d     = '0;
              n_d     = '0;
            end else begin
              state_d = StIdle;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      StData: begin
        if (s_tick) begin
          if (s_q == BitLast) begin
            s_d = '0;
            b_d = {rx_s, b_q[7:1]};
            if (n_q == DataLast) begin
              state_d = StStop;
            end else begin
              n_d = n_q + 3'd1;
            end
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      StStop: begin
        if (s_tick) begin
          if (s_q == StopLast) begin
            state_d = StIdle;
            dout_d  = b_q >> Shift;
            ferr_d  = ~rx_s;
            done_d  = 1'b1;
          end else begin
            s_d = s_q + SW'(1);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  assign dout      = dout_q;
  assign rx_done   = done_q;
  assign frame_err = ferr_q;

endmodule

// File: tb/tb_receptor_uart.sv
// Scoreboard bench for receptor_uart: an 8-bit/1-stop instance and a 7-bit/2-stop instance,
// driven with directed and random frames; a monitor checks every rx_done against the queue.
module tb_receptor_uart;

  typedef struct {
    logic [7:0] d;
    logic       fe;
    longint     tick;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       s_tick = 1'b0;
  logic       rx8 = 1'b1;
  logic       rx7 = 1'b1;
  logic [7:0] dout8, dout7;
  logic       done8, done7, ferr8, ferr7;
  logic       prev8 = 1'b0;
  logic       prev7 = 1'b0;

  longint tick_cnt = 0;
  longint cyc = 0;
  longint last_tick_cyc = -1;
  int     vectors = 0;
  int     miscompares = 0;
  exp_t   q8[$];
  exp_t   q7[$];

  receptor_uart #(.DBIT(8), .SB_TICK(16)) dut8 (
    .clk(clk), .reset(reset), .rx(rx8), .s_tick(s_tick),
    .dout(dout8), .rx_done(done8), .frame_err(ferr8)
  );

  receptor_uart #(.DBIT(7), .SB_TICK(32)) dut7 (
    .clk(clk), .reset(reset), .rx(rx7), .s_tick(s_tick),
    .dout(dout7), .rx_done(done7), .frame_err(ferr7)
  );

  always #5 clk = ~clk;

  // s_tick: one clock high out of every 16, changed on the falling edge.
  initial begin
    forever begin
      repeat (15) @(negedge clk);
      s_tick = 1'b1;
      @(negedge clk);
      s_tick = 1'b0;
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (s_tick) begin
      tick_cnt      <= tick_cnt + 1;
      last_tick_cyc <= cyc + 1;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic check_out(input int sel, input logic [7:0] d, input logic fe, input logic prev);
    exp_t e;
    check(sel ? "rx_done7_width" : "rx_done8_width", 64'(prev), 64'(0));
    if ((sel == 1 && q7.size() == 0) || (sel == 0 && q8.size() == 0)) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_rx_done dut%0d: got pulse dout=0x%0h, expected none", sel, d);
    end else begin
      e = (sel == 1) ? q7.pop_front() : q8.pop_front();
      check(sel ? "dout7" : "dout8", 64'(d), 64'(e.d));
      check(sel ? "frame_err7" : "frame_err8", 64'(fe), 64'(e.fe));
      if (e.tick >= 0) begin
        check("latency_ticks", 64'(tick_cnt), 64'(e.tick));
        check("rx_done_cycle", 64'(cyc), 64'(last_tick_cyc));
      end
    end
  endtask

  always @(negedge clk) begin
    if (done8) check_out(0, dout8, ferr8, prev8);
    if (done7) check_out(1, dout7, ferr7, prev7);
    prev8 <= done8;
    prev7 <= done7;
  end

  task automatic wait_ticks(input int k);
    for (int i = 0; i < k; i++) begin
      @(posedge clk);
      while (!s_tick) @(posedge clk);
    end
    #1;
  endtask

  task automatic drive(input int sel, input logic v);
    if (sel == 1) rx7 = v;
    else rx8 = v;
  endtask

  function automatic int nbits(input int sel);
    return (sel == 1) ? 7 : 8;
  endfunction

  function automatic int nstop(input int sel);
    return (sel == 1) ? 32 : 16;
  endfunction

  function automatic longint frame_len(input int sel);
    return longint'(8 + 16 * nbits(sel) + nstop(sel));
  endfunction

  task automatic push(input int sel, input exp_t e);
    if (sel == 1) q7.push_back(e);
    else q8.push_back(e);
  endtask

  // Whole frame starting right after a tick; a bad stop bit goes high 3 ticks before its end.
  task automatic send_frame(input int sel, input logic [7:0] data, input bit good, input int gap);
    exp_t e;
    int   d;
    d = nbits(sel);
    drive(sel, 1'b0);
    e.d    = 8'(int'(data) % (1 << d));
    e.fe   = !good;
    e.tick = tick_cnt + frame_len(sel);
    push(sel, e);
    wait_ticks(16);
    for (int i = 0; i < d; i++) begin
      drive(sel, data[i]);
      wait_ticks(16);
    end
    if (good) begin
      drive(sel, 1'b1);
      wait_ticks(nstop(sel));
    end else begin
      drive(sel, 1'b0);
      wait_ticks(nstop(sel) - 3);
      drive(sel, 1'b1);
      wait_ticks(3);
    end
    wait_ticks(gap);
  endtask

  // Line held low across two full frame times: two break reports, then a glitch.
  task automatic send_break(input int sel);
    exp_t e;
    e.d  = 8'h00;
    e.fe = 1'b1;
    drive(sel, 1'b0);
    e.tick = tick_cnt + frame_len(sel);
    push(sel, e);
    e.tick = tick_cnt + 2 * frame_len(sel);
    push(sel, e);
    wait_ticks(int'(2 * frame_len(sel)) + 5);
    drive(sel, 1'b1);
    wait_ticks(16);
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check("reset_dout8", 64'(dout8), 64'(0));
    check("reset_rx_done8", 64'(done8), 64'(0));
    check("reset_frame_err8", 64'(ferr8), 64'(0));
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] abort_data;
    exp_t e;
    repeat (5) @(negedge clk);
    check("reset_dout8", 64'(dout8), 64'(0));
    check("reset_rx_done8", 64'(done8), 64'(0));
    check("reset_frame_err8", 64'(ferr8), 64'(0));
    check("reset_dout7", 64'(dout7), 64'(0));
    check("reset_rx_done7", 64'(done7), 64'(0));
    check("reset_frame_err7", 64'(ferr7), 64'(0));
    reset = 1'b0;
    wait_ticks(2);

    send_frame(0, 8'h55, 1'b1, 2);

    // Start-bit glitch: nothing reported, outputs held.
    rx8 = 1'b0;
    wait_ticks(4);
    rx8 = 1'b1;
    wait_ticks(20);
    check("glitch_dout8", 64'(dout8), 64'(8'h55));
    check("glitch_frame_err8", 64'(ferr8), 64'(0));

    send_frame(0, 8'hA3, 1'b0, 2);
    send_frame(0, 8'h00, 1'b1, 0);
    send_frame(0, 8'hFF, 1'b1, 2);

    // Reset halfway through data bit 4 of 0x3C aborts the frame.
    abort_data = 8'h3C;
    rx8 = 1'b0;
    wait_ticks(16);
    for (int i = 0; i < 4; i++) begin
      rx8 = abort_data[i];
      wait_ticks(16);
    end
    rx8 = abort_data[4];
    wait_ticks(8);
    pulse_reset();
    rx8 = 1'b1;
    wait_ticks(40);
    send_frame(0, 8'h81, 1'b1, 2);

    send_break(0);

    // Line already low when reset releases counts as a start bit.
    rx8 = 1'b0;
    e.d    = 8'hC6;
    e.fe   = 1'b0;
    e.tick = -1;
    q8.push_back(e);
    wait_ticks(3);
    pulse_reset();
    wait_ticks(13);
    for (int i = 0; i < 8; i++) begin
      rx8 = e.d[i];
      wait_ticks(16);
    end
    rx8 = 1'b1;
    wait_ticks(18);

    for (int i = 0; i < 30; i++) begin
      send_frame(0, 8'($urandom), $urandom_range(0, 4) != 0, int'($urandom_range(0, 3)));
    end

    send_frame(1, 8'h5A, 1'b1, 2);
    send_frame(1, 8'hD3, 1'b0, 0);
    for (int i = 0; i < 12; i++) begin
      send_frame(1, 8'($urandom), $urandom_range(0, 4) != 0, int'($urandom_range(0, 3)));
    end
    send_break(1);

    wait_ticks(40);
    check("pending_frames8", 64'(q8.size()), 64'(0));
    check("pending_frames7", 64'(q7.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
